id_ex_stage: RTL and testbench

ID/EX pipeline register for the five-stage RISC-V core, sitting directly upstream of the ALU. It captures decoded operands and control from the decode stage and drives the ALU operand and control inputs (`in1`, `in2`, `id_ex_enable`, `id_ex_alu_control`). It also performs operand forwarding from EX/MEM and MEM/WB, and detects load-use hazards, inserting one bubble per hazard. One-cycle latency, with stall (hold) and flush (bubble) control.

---
 rtl/id_ex_stage.sv | 170 +++++++++++++++++
 tb/tb_id_ex_stage.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register of the five-stage RISC-V core.
// Captures decoded operands/control from decode and feeds the ALU. Resolves
// operands from EX/MEM and MEM/WB and detects hazards needing a bubble.
//
// Build option: ID_EX_FORWARDING_EN
//   defined   - EX/MEM and MEM/WB forwarding muxes; stall on load-use only.
//   undefined - operands straight from the pipeline register; stall on any
//               RAW hazard against an in-flight writer.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   id_*                  decoded instruction from the decode stage
//   stall_in, flush       downstream hold / kill the instruction entering EX
//   exm_*, wb_*           EX/MEM and MEM/WB writeback info (forwarding/hazards)
//   in1, in2              ALU operands
//   id_ex_enable          EX slot valid (ALU enable)
//   id_ex_alu_control     registered ALU opcode
//   ex_*                  registered control/PC and forwarded store data
//   load_use_stall        asks decode/fetch to hold this cycle
module id_ex_stage #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [4:0]      id_rs1,
  input  logic [4:0]      id_rs2,
  input  logic [4:0]      id_rd,
  input  logic            id_alu_src,
  input  logic [3:0]      id_alu_control,
  input  logic            id_reg_write,
  input  logic            id_mem_read,
  input  logic            id_mem_write,
  input  logic            stall_in,
  input  logic            flush,
  input  logic [4:0]      exm_rd,
  input  logic            exm_reg_write,
  input  logic [XLEN-1:0] exm_result,
  input  logic [4:0]      wb_rd,
  input  logic            wb_reg_write,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] in1,
  output logic [XLEN-1:0] in2,
  output logic            id_ex_enable,
  output logic [3:0]      id_ex_alu_control,
  output logic [4:0]      ex_rd,
  output logic            ex_reg_write,
  output logic            ex_mem_read,
  output logic            ex_mem_write,
  output logic [XLEN-1:0] ex_pc,
  output logic [XLEN-1:0] ex_store_data,
  output logic            load_use_stall
);

  logic            valid_q;
  logic [XLEN-1:0] pc_q;
  logic [XLEN-1:0] rs1_data_q;
  logic [XLEN-1:0] rs2_data_q;
  logic [XLEN-1:0] imm_q;
  logic [4:0]      rs1_q;
  logic [4:0]      rs2_q;
  logic [4:0]      rd_q;
  logic            alu_src_q;
  logic [3:0]      alu_control_q;
  logic            reg_write_q;
  logic            mem_read_q;
  logic            mem_write_q;

  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

`ifdef ID_EX_FORWARDING_EN
  // EX/MEM is younger than MEM/WB, so it wins; x0 is never forwarded.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs1_q))
      fwd_rs1 = exm_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs1_q))
      fwd_rs1 = wb_data;

    fwd_rs2 = rs2_data_q;
    if (exm_reg_write && (exm_rd != '0) && (exm_rd == rs2_q))
      fwd_rs2 = exm_result;
    else if (wb_reg_write && (wb_rd != '0) && (wb_rd == rs2_q))
      fwd_rs2 = wb_data;
  end

  // Only a load in EX cannot be forwarded in time.
  assign load_use_stall = id_valid && valid_q && mem_read_q && (rd_q != '0) &&
                          ((rd_q == id_rs1) || (rd_q == id_rs2));
`else
  logic raw_rs1;
  logic raw_rs2;
  logic unused_fwd;

  assign fwd_rs1 = rs1_data_q;
  assign fwd_rs2 = rs2_data_q;

  // Without forwarding, any pending writer of a source register must drain
  // into the register file (written first half) before decode proceeds.
  always_comb begin
    raw_rs1 = (id_rs1 != '0) &&
              ((valid_q && reg_write_q && (rd_q == id_rs1)) ||
               (exm_reg_write && (exm_rd == id_rs1)) ||
               (wb_reg_write && (wb_rd == id_rs1)));
    raw_rs2 = (id_rs2 != '0) &&
              ((valid_q && reg_write_q && (rd_q == id_rs2)) ||
               (exm_reg_write && (exm_rd == id_rs2)) ||
               (wb_reg_write && (wb_rd == id_rs2)));
  end

  assign load_use_stall = id_valid && (raw_rs1 || raw_rs2);
  assign unused_fwd     = ^{exm_result, wb_data, rs1_q, rs2_q};
`endif

  // Priority flush > stall_in > load_use_stall > capture. A bubble only
  // clears valid and the side-effecting controls; data fields are left as-is.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q       <= 1'b0;
      pc_q          <= '0;
      rs1_data_q    <= '0;
      rs2_data_q    <= '0;
      imm_q         <= '0;
      rs1_q         <= '0;
      rs2_q         <= '0;
      rd_q          <= '0;
      alu_src_q     <= 1'b0;
      alu_control_q <= '0;
      reg_write_q   <= 1'b0;
      mem_read_q    <= 1'b0;
      mem_write_q   <= 1'b0;
    end else if (flush || (!stall_in && load_use_stall)) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (!stall_in) begin
      valid_q       <= id_valid;
      pc_q          <= id_pc;
      rs1_data_q    <= id_rs1_data;
      rs2_data_q    <= id_rs2_data;
      imm_q         <= id_imm;
      rs1_q         <= id_rs1;
      rs2_q         <= id_rs2;
      rd_q          <= id_rd;
      alu_src_q     <= id_alu_src;
      alu_control_q <= id_alu_control;
      reg_write_q   <= id_reg_write;
      mem_read_q    <= id_mem_read;
      mem_write_q   <= id_mem_write;
    end
  end

  assign in1               = fwd_rs1;
  assign in2               = alu_src_q ? imm_q : fwd_rs2;
  assign ex_store_data     = fwd_rs2;
  assign id_ex_enable      = valid_q;
  assign id_ex_alu_control = alu_control_q;
  assign ex_rd             = rd_q;
  assign ex_reg_write      = reg_write_q;
  assign ex_mem_read       = mem_read_q;
  assign ex_mem_write      = mem_write_q;
  assign ex_pc             = pc_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: self-checking bench for id_ex_stage.
// Directed table of vectors, hand-written multi-cycle sequences (load-use,
// flush+stall, stall+hazard, async reset) and a randomised run checked
// against a behavioural model through an expected-result queue.
module tb_id_ex_stage;

`ifdef ID_EX_FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        id_valid;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_alu_src;
  logic [3:0]  id_alu_control;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        stall_in, flush;
  logic [4:0]  exm_rd;
  logic        exm_reg_write;
  logic [31:0] exm_result;
  logic [4:0]  wb_rd;
  logic        wb_reg_write;
  logic [31:0] wb_data;
  logic [31:0] in1, in2, ex_pc, ex_store_data;
  logic        id_ex_enable;
  logic [3:0]  id_ex_alu_control;
  logic [4:0]  ex_rd;
  logic        ex_reg_write, ex_mem_read, ex_mem_write;
  logic        load_use_stall;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32)) dut (
    .clk(clk), .reset_n(reset_n), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_alu_src(id_alu_src),
    .id_alu_control(id_alu_control), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .stall_in(stall_in), .flush(flush), .exm_rd(exm_rd),
    .exm_reg_write(exm_reg_write), .exm_result(exm_result), .wb_rd(wb_rd),
    .wb_reg_write(wb_reg_write), .wb_data(wb_data), .in1(in1), .in2(in2),
    .id_ex_enable(id_ex_enable), .id_ex_alu_control(id_ex_alu_control),
    .ex_rd(ex_rd), .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read),
    .ex_mem_write(ex_mem_write), .ex_pc(ex_pc), .ex_store_data(ex_store_data),
    .load_use_stall(load_use_stall)
  );

  typedef struct {
    logic v; logic [31:0] pc, r1d, r2d, imm; logic [4:0] rs1, rs2, rd;
    logic src; logic [3:0] ctl; logic rw, mr, mw, stall, flush;
    logic [4:0] exm_rd; logic exm_rw; logic [31:0] exm_res;
    logic [4:0] wb_rd; logic wb_rw; logic [31:0] wb_data;
  } stim_t;

  typedef struct {
    logic en; logic [31:0] in1, in2, sd; logic [3:0] ctl; logic lus;
  } exp_t;

  typedef struct { stim_t s; exp_t e; } vec_t;

  typedef struct {
    logic v; logic [31:0] pc, r1d, r2d, imm; logic [4:0] rs1, rs2, rd;
    logic src; logic [3:0] ctl; logic rw, mr, mw;
  } mstate_t;

  typedef struct {
    logic en; logic [31:0] in1, in2, sd, pc; logic [3:0] ctl; logic [4:0] rd;
    logic rw, mr, mw, lus;
  } full_t;

  int errors = 0;
  int checks = 0;
  full_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic stim_t zero_stim();
    stim_t s;
    s.v = 0; s.pc = 0; s.r1d = 0; s.r2d = 0; s.imm = 0; s.rs1 = 0; s.rs2 = 0;
    s.rd = 0; s.src = 0; s.ctl = 0; s.rw = 0; s.mr = 0; s.mw = 0; s.stall = 0;
    s.flush = 0; s.exm_rd = 0; s.exm_rw = 0; s.exm_res = 0; s.wb_rd = 0;
    s.wb_rw = 0; s.wb_data = 0;
    return s;
  endfunction

  function automatic stim_t ins(input logic v, input logic [31:0] r1d, r2d, imm,
                                input logic [4:0] rs1, rs2, rd, input logic src,
                                input logic [3:0] ctl, input logic rw, mr);
    stim_t s = zero_stim();
    s.v = v; s.r1d = r1d; s.r2d = r2d; s.imm = imm; s.rs1 = rs1; s.rs2 = rs2;
    s.rd = rd; s.src = src; s.ctl = ctl; s.rw = rw; s.mr = mr;
    return s;
  endfunction

  function automatic exp_t ex(input logic en, input logic [31:0] a, b, sd,
                              input logic [3:0] ctl, input logic lus);
    exp_t e;
    e.en = en; e.in1 = a; e.in2 = b; e.sd = sd; e.ctl = ctl; e.lus = lus;
    return e;
  endfunction

  task automatic drive(input stim_t s);
    id_valid = s.v; id_pc = s.pc; id_rs1_data = s.r1d; id_rs2_data = s.r2d;
    id_imm = s.imm; id_rs1 = s.rs1; id_rs2 = s.rs2; id_rd = s.rd;
    id_alu_src = s.src; id_alu_control = s.ctl; id_reg_write = s.rw;
    id_mem_read = s.mr; id_mem_write = s.mw; stall_in = s.stall; flush = s.flush;
    exm_rd = s.exm_rd; exm_reg_write = s.exm_rw; exm_result = s.exm_res;
    wb_rd = s.wb_rd; wb_reg_write = s.wb_rw; wb_data = s.wb_data;
  endtask

  // One cycle: drive just after the edge, sample well before the next one.
  task automatic cyc(input stim_t s);
    @(posedge clk);
    #1 drive(s);
    #3;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, ".en"},   id_ex_enable, 0);
    chk({tag, ".in1"},  in1, 0);
    chk({tag, ".in2"},  in2, 0);
    chk({tag, ".ctl"},  id_ex_alu_control, 0);
    chk({tag, ".rd"},   ex_rd, 0);
    chk({tag, ".rw"},   ex_reg_write, 0);
    chk({tag, ".mr"},   ex_mem_read, 0);
    chk({tag, ".mw"},   ex_mem_write, 0);
    chk({tag, ".pc"},   ex_pc, 0);
    chk({tag, ".sd"},   ex_store_data, 0);
    chk({tag, ".lus"},  load_use_stall, 0);
  endtask

  // Behavioural reference model for the random phase.
  function automatic logic [31:0] m_fwd(input stim_t s, input logic [4:0] rs, input logic [31:0] d);
    if (FWD && s.exm_rw && s.exm_rd != 0 && s.exm_rd == rs) return s.exm_res;
    if (FWD && s.wb_rw && s.wb_rd != 0 && s.wb_rd == rs) return s.wb_data;
    return d;
  endfunction

  function automatic logic m_hit(input mstate_t m, input stim_t s, input logic [4:0] r);
    return (r != 0) && ((m.v && m.rw && m.rd == r) || (s.exm_rw && s.exm_rd == r) ||
                        (s.wb_rw && s.wb_rd == r));
  endfunction

  function automatic full_t m_out(input mstate_t m, input stim_t s);
    full_t o;
    o.en = m.v; o.pc = m.pc; o.ctl = m.ctl; o.rd = m.rd;
    o.rw = m.rw; o.mr = m.mr; o.mw = m.mw;
    o.in1 = m_fwd(s, m.rs1, m.r1d);
    o.sd  = m_fwd(s, m.rs2, m.r2d);
    o.in2 = m.src ? m.imm : o.sd;
    if (FWD)
      o.lus = s.v && m.v && m.mr && m.rd != 0 && (m.rd == s.rs1 || m.rd == s.rs2);
    else
      o.lus = s.v && (m_hit(m, s, s.rs1) || m_hit(m, s, s.rs2));
    return o;
  endfunction

  function automatic mstate_t m_next(input mstate_t m, input stim_t s, input logic lus);
    mstate_t n = m;
    if (s.flush || (!s.stall && lus)) begin
      n.v = 0; n.rw = 0; n.mr = 0; n.mw = 0;
    end else if (!s.stall) begin
      n.v = s.v; n.pc = s.pc; n.r1d = s.r1d; n.r2d = s.r2d; n.imm = s.imm;
      n.rs1 = s.rs1; n.rs2 = s.rs2; n.rd = s.rd; n.src = s.src; n.ctl = s.ctl;
      n.rw = s.rw; n.mr = s.mr; n.mw = s.mw;
    end
    return n;
  endfunction

  localparam int NT = 8;
  vec_t tbl [NT];

  initial begin
    stim_t s, d, g;
    mstate_t m;
    full_t e, o;

    // Row k: inputs during cycle k, outputs reflect what the edge before it captured.
    tbl[0].s = ins(1, 5, 7, 0, 1, 2, 3, 0, 4'h0, 1, 0);
    tbl[0].e = ex(0, 0, 0, 0, 4'h0, 0);
    tbl[1].s = ins(1, 9, 32'h55, 32'hFFFFFFFC, 5, 6, 7, 1, 4'h8, 1, 0);
    tbl[1].e = ex(1, 5, 7, 7, 4'h0, 0);
    tbl[2].s = ins(1, 32'h33, 32'h44, 0, 3, 0, 8, 0, 4'h0, 1, 0);
    tbl[2].e = ex(1, 9, 32'hFFFFFFFC, 32'h55, 4'h8, 0);
    tbl[3].s = zero_stim(); tbl[3].s.stall = 1;
    tbl[3].s.exm_rd = 3; tbl[3].s.exm_rw = 1; tbl[3].s.exm_res = 32'h11;
    tbl[3].s.wb_rd = 3; tbl[3].s.wb_rw = 1; tbl[3].s.wb_data = 32'h22;
    tbl[3].e = ex(1, FWD ? 32'h11 : 32'h33, 32'h44, 32'h44, 4'h0, 0);
    tbl[4].s = tbl[3].s; tbl[4].s.exm_rw = 0;
    tbl[4].e = ex(1, FWD ? 32'h22 : 32'h33, 32'h44, 32'h44, 4'h0, 0);
    tbl[5].s = zero_stim(); tbl[5].s.stall = 1;
    tbl[5].s.exm_rd = 0; tbl[5].s.exm_rw = 1; tbl[5].s.exm_res = 32'hAA;
    tbl[5].s.wb_rd = 0; tbl[5].s.wb_rw = 1; tbl[5].s.wb_data = 32'hBB;
    tbl[5].e = ex(1, 32'h33, 32'h44, 32'h44, 4'h0, 0);
    tbl[6].s = ins(1, 32'h100, 0, 8, 1, 0, 4, 1, 4'h0, 1, 1);
    tbl[6].e = ex(1, 32'h33, 32'h44, 32'h44, 4'h0, 0);
    tbl[7].s = ins(1, 1, 32'hDEAD, 0, 9, 4, 10, 0, 4'h0, 1, 0);
    tbl[7].e = ex(1, 32'h100, 8, 0, 4'h0, 1);

    reset_n = 0;
    drive(zero_stim());
    repeat (2) @(posedge clk);
    #1 chk_zero("reset");
    @(negedge clk) reset_n = 1;

    for (int i = 0; i < NT; i++) begin
      cyc(tbl[i].s);
      chk($sformatf("t%0d.en", i),  id_ex_enable,      tbl[i].e.en);
      chk($sformatf("t%0d.in1", i), in1,               tbl[i].e.in1);
      chk($sformatf("t%0d.in2", i), in2,               tbl[i].e.in2);
      chk($sformatf("t%0d.sd", i),  ex_store_data,     tbl[i].e.sd);
      chk($sformatf("t%0d.ctl", i), id_ex_alu_control, tbl[i].e.ctl);
      chk($sformatf("t%0d.lus", i), load_use_stall,    tbl[i].e.lus);
    end

    // Load-use: bubble enters EX, then the dependent instruction proceeds.
    d = tbl[7].s;
    s = d; s.exm_rd = 4; s.exm_rw = 1; s.exm_res = 32'h77;
    cyc(s);
    chk("lu.bubble.en", id_ex_enable, 0);
`ifdef ID_EX_FORWARDING_EN
    chk("lu.bubble.lus", load_use_stall, 0);
    s = zero_stim(); s.wb_rd = 4; s.wb_rw = 1; s.wb_data = 32'h99;
    cyc(s);
    chk("lu.dep.en", id_ex_enable, 1);
    chk("lu.dep.in1", in1, 1);
    chk("lu.dep.in2", in2, 32'h99);
    chk("lu.dep.sd", ex_store_data, 32'h99);
    chk("lu.dep.rd", ex_rd, 10);
    chk("lu.dep.lus", load_use_stall, 0);
`else
    chk("lu.bubble.lus", load_use_stall, 1);
    s = d; s.wb_rd = 4; s.wb_rw = 1; s.wb_data = 32'h99;
    cyc(s);
    chk("lu.wb.en", id_ex_enable, 0);
    chk("lu.wb.lus", load_use_stall, 1);
    cyc(d);
    chk("lu.clear.en", id_ex_enable, 0);
    chk("lu.clear.lus", load_use_stall, 0);
    cyc(zero_stim());
    chk("lu.dep.en", id_ex_enable, 1);
    chk("lu.dep.in1", in1, 1);
    chk("lu.dep.in2", in2, 32'hDEAD);
    chk("lu.dep.rd", ex_rd, 10);
`endif

    // flush together with stall_in: flush wins.
    s = ins(1, 32'h10, 32'h20, 0, 0, 0, 11, 0, 4'h3, 1, 0);
    cyc(s);
    s.flush = 1; s.stall = 1;
    cyc(s);
    chk("fs.before.en", id_ex_enable, 1);
    chk("fs.before.rd", ex_rd, 11);
    cyc(zero_stim());
    chk("fs.after.en", id_ex_enable, 0);
    chk("fs.after.rw", ex_reg_write, 0);

    // stall_in together with a load-use hazard: hold wins, stall stays high.
    cyc(ins(1, 0, 0, 0, 0, 0, 6, 0, 4'h0, 1, 1));
    g = ins(1, 32'h5A, 0, 0, 6, 0, 12, 0, 4'h2, 1, 0);
    g.pc = 32'h40; g.stall = 1;
    cyc(g);
    chk("sh.lus0", load_use_stall, 1);
    cyc(g);
    chk("sh.hold.en", id_ex_enable, 1);
    chk("sh.hold.mr", ex_mem_read, 1);
    chk("sh.hold.rd", ex_rd, 6);
    chk("sh.hold.lus", load_use_stall, 1);
    g.stall = 0;
    cyc(g);
    chk("sh.release.lus", load_use_stall, 1);
    cyc(g);
    chk("sh.bubble.en", id_ex_enable, 0);
    chk("sh.bubble.lus", load_use_stall, 0);
    cyc(zero_stim());
    chk("sh.cap.en", id_ex_enable, 1);
    chk("sh.cap.in1", in1, 32'h5A);
    chk("sh.cap.ctl", id_ex_alu_control, 2);
    chk("sh.cap.pc", ex_pc, 32'h40);

    // Asynchronous reset between edges.
    #1 reset_n = 0;
    #1 chk_zero("areset");
    @(negedge clk) reset_n = 1;

    // Randomised run against the model.
    m.v = 0; m.pc = 0; m.r1d = 0; m.r2d = 0; m.imm = 0; m.rs1 = 0; m.rs2 = 0;
    m.rd = 0; m.src = 0; m.ctl = 0; m.rw = 0; m.mr = 0; m.mw = 0;
    for (int n = 0; n < 400; n++) begin
      @(posedge clk);
      #1;
      s.v = ($urandom_range(0, 9) != 0);
      s.pc = $urandom; s.r1d = $urandom; s.r2d = $urandom; s.imm = $urandom;
      s.rs1 = 5'($urandom_range(0, 7)); s.rs2 = 5'($urandom_range(0, 7));
      s.rd = 5'($urandom_range(0, 7)); s.src = 1'($urandom);
      s.ctl = 4'($urandom_range(0, 8)); s.rw = 1'($urandom);
      s.mr = 1'($urandom); s.mw = 1'($urandom);
      s.stall = ($urandom_range(0, 9) == 0); s.flush = ($urandom_range(0, 9) == 0);
      s.exm_rd = 5'($urandom_range(0, 7)); s.exm_rw = 1'($urandom); s.exm_res = $urandom;
      s.wb_rd = 5'($urandom_range(0, 7)); s.wb_rw = 1'($urandom); s.wb_data = $urandom;
      drive(s);
      exp_q.push_back(m_out(m, s));
      #3;
      e = exp_q.pop_front();
      chk($sformatf("r%0d.en", n),  id_ex_enable,   e.en);
      chk($sformatf("r%0d.rw", n),  ex_reg_write,   e.rw);
      chk($sformatf("r%0d.mr", n),  ex_mem_read,    e.mr);
      chk($sformatf("r%0d.mw", n),  ex_mem_write,   e.mw);
      chk($sformatf("r%0d.lus", n), load_use_stall, e.lus);
      if (e.en) begin
        chk($sformatf("r%0d.in1", n), in1,               e.in1);
        chk($sformatf("r%0d.in2", n), in2,               e.in2);
        chk($sformatf("r%0d.sd", n),  ex_store_data,     e.sd);
        chk($sformatf("r%0d.pc", n),  ex_pc,             e.pc);
        chk($sformatf("r%0d.ctl", n), id_ex_alu_control, e.ctl);
        chk($sformatf("r%0d.rd", n),  ex_rd,             e.rd);
      end
      o = e;
      m = m_next(m, s, o.lus);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
